// File: rtl/brg_xcel_pkg.sv
// Shared types for the accelerator network receive pipe.
// Request classes, buffered entry layout and address decode.
package brg_xcel_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 28;
  localparam int X_W    = 6;
  localparam int Y_W    = 5;

  localparam int epa_word_addr_width_gp = 16;
  localparam int CSR_DRAM_ENABLE_IDX    = 7;

  typedef enum logic [1:0] {
    RX_CSR,
    RX_DRAM_EN,
    RX_MEM,
    RX_ILLEGAL
  } rx_class_e;

  typedef struct packed {
    rx_class_e             cls;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     data;
    logic [DATA_W/8-1:0]   mask;
    logic [X_W-1:0]        src_x;
    logic [Y_W-1:0]        src_y;
  } rx_entry_t;

  localparam int EPA = epa_word_addr_width_gp;

  function automatic rx_class_e rx_decode(
    input logic [ADDR_W-1:0] addr,
    input int                csr_num,
    input int                dmem_size
  );
    logic [31:0] a;
    logic        tile;
    a    = 32'(addr);
    tile = addr[EPA-1] && (addr[ADDR_W-1:EPA] == '0);
    if (tile) begin
      if (addr[EPA-2:0] == (EPA-1)'(4))
        return RX_DRAM_EN;
      return RX_ILLEGAL;
    end
    if (a < 32'(csr_num))
      return RX_CSR;
    if (a >= 32'(dmem_size) && a < 32'(2 * dmem_size))
      return RX_MEM;
    return RX_ILLEGAL;
  endfunction

endpackage

// File: rtl/brg_xcel_network_rx_pipe_if.sv
// Network-side request/response bundle of the rx pipe.
// master = network requester, slave = rx pipe.
interface brg_xcel_network_rx_pipe_if #(
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 28,
  parameter int x_cord_width_p = 6,
  parameter int y_cord_width_p = 5
);

  logic                      v_i;
  logic [data_width_p-1:0]   data_i;
  logic [data_width_p/8-1:0] mask_i;
  logic [addr_width_p-1:0]   addr_i;
  logic                      we_i;
  logic [x_cord_width_p-1:0] src_x_cord_i;
  logic [y_cord_width_p-1:0] src_y_cord_i;
  logic                      yumi_o;
  logic                      returning_v_o;
  logic [data_width_p-1:0]   returning_data_o;

  modport master (
    output v_i, data_i, mask_i, addr_i,
    output we_i, src_x_cord_i, src_y_cord_i,
    input  yumi_o, returning_v_o,
    input  returning_data_o
  );

  modport slave (
    input  v_i, data_i, mask_i, addr_i,
    input  we_i, src_x_cord_i, src_y_cord_i,
    output yumi_o, returning_v_o,
    output returning_data_o
  );

endinterface

// File: rtl/brg_xcel_rx_fifo.sv
// 1r1w request buffer with wrap-bit pointers.
// Storage is not reset; only the pointers are.
module brg_xcel_rx_fifo
  import brg_xcel_pkg::*;
#(
  parameter int els_p = 4
)(
  input  logic      clk_i,
  input  logic      reset_n_i,
  input  logic      enq_i,
  input  rx_entry_t data_i,
  input  logic      deq_i,
  output rx_entry_t data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int ptr_w = $clog2(els_p);

  rx_entry_t        mem [els_p];
  logic [ptr_w:0]   wr_ptr;
  logic [ptr_w:0]   rd_ptr;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq_i)
        wr_ptr <= wr_ptr + (ptr_w+1)'(1);
      if (deq_i)
        rd_ptr <= rd_ptr + (ptr_w+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_i)
      mem[wr_ptr[ptr_w-1:0]] <= data_i;
  end

  assign data_o  = mem[rd_ptr[ptr_w-1:0]];
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[ptr_w] != rd_ptr[ptr_w])
                && (wr_ptr[ptr_w-1:0] == rd_ptr[ptr_w-1:0]);

endmodule

// File: rtl/brg_xcel_network_rx_pipe.sv
// Network rx pipe: decode, buffer and issue requests to the
// accelerator; illegal accesses are answered locally with zero.
module brg_xcel_network_rx_pipe
  import brg_xcel_pkg::*;
#(
  parameter int data_width_p   = DATA_W,
  parameter int addr_width_p   = ADDR_W,
  parameter int x_cord_width_p = X_W,
  parameter int y_cord_width_p = Y_W,
  parameter int dmem_size_p    = 1024,
  parameter int csr_num_p      = 8,
  parameter int fifo_els_p     = 4,
  parameter int max_out_p      = 4
)(
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  brg_xcel_network_rx_pipe_if.slave net,
  output logic                      rx_v_o,
  input  logic                      rx_yumi_i,
  output logic                      rx_we_o,
  output logic [addr_width_p-1:0]   rx_addr_o,
  output logic [data_width_p-1:0]   rx_wdata_o,
  output logic [data_width_p/8-1:0] rx_mask_o,
  output logic                      rx_is_csr_o,
  output logic                      rx_is_local_mem_o,
  output logic [x_cord_width_p-1:0] rx_src_x_o,
  output logic [y_cord_width_p-1:0] rx_src_y_o,
  input  logic                      rx_returning_v_i,
  input  logic [data_width_p-1:0]   rx_returning_data_i,
  output logic                      err_o,
  output logic [addr_width_p-1:0]   err_addr_o,
  input  logic                      err_clear_i
);

  localparam int cnt_w = $clog2(max_out_p + 1);

  rx_entry_t        enq_entry;
  rx_entry_t        head;
  rx_class_e        enq_cls;
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;
  logic             issue;
  logic             ill_pop;
  logic             head_ill;
  logic             can_issue;
  logic             ill_resp_r;
  logic [cnt_w-1:0] out_cnt;
  logic             unused_dbg;

  assign unused_dbg = ^{my_x_i, my_y_i};

  always_comb begin
    enq_cls         = rx_decode(net.addr_i, csr_num_p,
                                dmem_size_p);
    enq_entry       = '0;
    enq_entry.cls   = enq_cls;
    enq_entry.we    = net.we_i;
    enq_entry.addr  = net.addr_i;
    enq_entry.data  = net.data_i;
    enq_entry.mask  = net.mask_i;
    enq_entry.src_x = net.src_x_cord_i;
    enq_entry.src_y = net.src_y_cord_i;
    if (enq_cls == RX_DRAM_EN)
      enq_entry.addr = ADDR_W'(CSR_DRAM_ENABLE_IDX);
  end

  brg_xcel_rx_fifo #(
    .els_p (fifo_els_p)
  ) fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enq_i     (enq),
    .data_i    (enq_entry),
    .deq_i     (deq),
    .data_o    (head),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign enq        = reset_n_i & net.v_i & ~full;
  assign net.yumi_o = enq;

  assign head_ill  = ~empty & (head.cls == RX_ILLEGAL);
  assign can_issue = out_cnt < cnt_w'(max_out_p);
  assign rx_v_o    = reset_n_i & ~empty & ~head_ill
                   & can_issue;
  assign issue     = rx_v_o & rx_yumi_i;
  // Illegal heads drain only once older responses are out.
  assign ill_pop   = reset_n_i & head_ill & (out_cnt == '0);
  assign deq       = issue | ill_pop;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_cnt <= '0;
    end else begin
      unique case ({issue, rx_returning_v_i})
        2'b10:   out_cnt <= out_cnt + cnt_w'(1);
        2'b01:   if (out_cnt != '0)
                   out_cnt <= out_cnt - cnt_w'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      ill_resp_r <= 1'b0;
    else
      ill_resp_r <= ill_pop;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if (ill_pop && (!err_o || err_clear_i)) begin
      err_o      <= 1'b1;
      err_addr_o <= head.addr;
    end else if (err_clear_i) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end
  end

  assign net.returning_v_o    = reset_n_i
                              & (rx_returning_v_i | ill_resp_r);
  assign net.returning_data_o = (reset_n_i & rx_returning_v_i)
                              ? rx_returning_data_i : '0;

  assign rx_we_o           = ~empty & head.we;
  assign rx_addr_o         = empty ? '0 : head.addr;
  assign rx_wdata_o        = empty ? '0 : head.data;
  assign rx_mask_o         = empty ? '0 : head.mask;
  assign rx_src_x_o        = empty ? '0 : head.src_x;
  assign rx_src_y_o        = empty ? '0 : head.src_y;
  assign rx_is_csr_o       = ~empty & ((head.cls == RX_CSR)
                           | (head.cls == RX_DRAM_EN));
  assign rx_is_local_mem_o = ~empty & (head.cls == RX_MEM);

  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(rx_returning_v_i && ill_resp_r));
      assert (!(rx_returning_v_i && out_cnt == '0));
    end
  end

endmodule

// File: tb/tb_brg_xcel_network_rx_pipe.sv
// Randomized bench for the rx pipe against a queue-based model.
// Directed scenarios first, then a random traffic phase.
module tb_brg_xcel_network_rx_pipe;

  localparam int DMEM = 1024;
  localparam int DEPTH = 4;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  my_x = 6'd3;
  logic [4:0]  my_y = 5'd2;
  logic        rx_v, rx_yumi, rx_we, rx_is_csr, rx_is_mem;
  logic [27:0] rx_addr, err_addr;
  logic [31:0] rx_wdata, ret_data;
  logic [3:0]  rx_mask;
  logic [5:0]  rx_src_x;
  logic [4:0]  rx_src_y;
  logic        ret_v, err, clr;

  always #5 clk = ~clk;

  brg_xcel_network_rx_pipe_if net ();

  brg_xcel_network_rx_pipe dut (
    .clk_i               (clk),
    .reset_n_i           (rst_n),
    .my_x_i              (my_x),
    .my_y_i              (my_y),
    .net                 (net),
    .rx_v_o              (rx_v),
    .rx_yumi_i           (rx_yumi),
    .rx_we_o             (rx_we),
    .rx_addr_o           (rx_addr),
    .rx_wdata_o          (rx_wdata),
    .rx_mask_o           (rx_mask),
    .rx_is_csr_o         (rx_is_csr),
    .rx_is_local_mem_o   (rx_is_mem),
    .rx_src_x_o          (rx_src_x),
    .rx_src_y_o          (rx_src_y),
    .rx_returning_v_i    (ret_v),
    .rx_returning_data_i (ret_data),
    .err_o               (err),
    .err_addr_o          (err_addr),
    .err_clear_i         (clr)
  );

  typedef struct {
    int          cls;
    logic        we;
    logic [27:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [5:0]  sx;
    logic [4:0]  sy;
  } req_t;

  req_t        q[$];
  int          outs;
  bit          ill_resp;
  bit          m_err;
  logic [27:0] m_err_addr;
  int          n_checks;
  int          n_errors;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // 0 csr, 1 dram enable, 2 mem, 3 illegal
  function automatic int classify(logic [27:0] a);
    int u;
    u = int'(a);
    if (u / 32768 == 1) return (u % 32768 == 4) ? 1 : 3;
    if (u < 8) return 0;
    if (u >= DMEM && u < 2 * DMEM) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    q.delete();
    outs = 0;
    ill_resp = 0;
    m_err = 0;
    m_err_addr = '0;
  endtask

  task automatic idle();
    net.v_i = 1'b0;
    rx_yumi = 1'b0;
    ret_v = 1'b0;
    clr = 1'b0;
  endtask

  task automatic set_req(logic [27:0] a, logic w,
                         logic [31:0] d);
    net.v_i = 1'b1;
    net.addr_i = a;
    net.we_i = w;
    net.data_i = d;
    net.mask_i = 4'($urandom);
    net.src_x_cord_i = 6'($urandom);
    net.src_y_cord_i = 5'($urandom);
  endtask

  task automatic tick();
    bit   ne, e_yumi, e_rxv, issue, illpop, r, c;
    req_t h, nr;
    #1;
    ne = q.size() > 0;
    if (ne) h = q[0];
    e_yumi = net.v_i && q.size() < DEPTH;
    e_rxv = ne && h.cls != 3 && outs < MAXO;
    chk("yumi", net.yumi_o, e_yumi);
    chk("rx_v", rx_v, e_rxv);
    if (e_rxv) begin
      chk("rx_addr", rx_addr, h.cls == 1 ? 28'd7 : h.addr);
      chk("rx_we", rx_we, h.we);
      chk("rx_wdata", rx_wdata, h.data);
      chk("rx_mask", rx_mask, h.mask);
      chk("rx_src", {rx_src_x, rx_src_y}, {h.sx, h.sy});
      chk("rx_is_csr", rx_is_csr, h.cls <= 1);
      chk("rx_is_mem", rx_is_mem, h.cls == 2);
    end
    chk("ret_v", net.returning_v_o, ret_v || ill_resp);
    chk("ret_data", net.returning_data_o,
        ret_v ? ret_data : 32'h0);
    chk("err", err, m_err);
    chk("err_addr", err_addr, m_err_addr);
    issue = e_rxv && rx_yumi;
    illpop = ne && h.cls == 3 && outs == 0;
    r = ret_v;
    c = clr;
    nr.cls = classify(net.addr_i);
    nr.we = net.we_i;
    nr.addr = net.addr_i;
    nr.data = net.data_i;
    nr.mask = net.mask_i;
    nr.sx = net.src_x_cord_i;
    nr.sy = net.src_y_cord_i;
    @(posedge clk);
    if (issue || illpop) void'(q.pop_front());
    if (e_yumi) q.push_back(nr);
    outs = outs + int'(issue) - int'(r);
    ill_resp = illpop;
    if (illpop && (!m_err || c)) begin
      m_err = 1;
      m_err_addr = h.addr;
    end else if (c) begin
      m_err = 0;
      m_err_addr = '0;
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0 && outs == 0 && !ill_resp) break;
      net.v_i = 1'b0;
      clr = 1'b0;
      rx_yumi = 1'b1;
      ret_v = (outs > 0) ? 1'($urandom) : 1'b0;
      ret_data = $urandom;
      tick();
    end
    idle();
  endtask

  function automatic logic [27:0] rand_addr();
    case ($urandom % 6)
      0, 1:    return 28'(DMEM + $urandom % DMEM);
      2:       return 28'($urandom % 8);
      3:       return 28'h8004;
      4:       return 28'(32'h8000 + $urandom % 8);
      default: return 28'($urandom);
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    idle();
    ret_data = '0;
    set_req(28'd1024, 1'b1, 32'h5);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_yumi", net.yumi_o, 1'b0);
    chk("rst_rx_v", rx_v, 1'b0);
    chk("rst_ret_v", net.returning_v_o, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_addr", err_addr, 28'h0);
    idle();
    rst_n = 1'b1;

    set_req(28'd1024, 1'b1, 32'h5);
    #1 chk("t1_yumi", net.yumi_o, 1'b1);
    tick();
    idle();
    #1;
    chk("t1_rx_v", rx_v, 1'b1);
    chk("t1_is_mem", rx_is_mem, 1'b1);
    chk("t1_addr", rx_addr, 28'd1024);
    chk("t1_wdata", rx_wdata, 32'h5);
    rx_yumi = 1'b1;
    tick();
    rx_yumi = 1'b0;
    ret_v = 1'b1;
    ret_data = 32'hAB;
    #1;
    chk("t1_resp_v", net.returning_v_o, 1'b1);
    chk("t1_resp_d", net.returning_data_o, 32'hAB);
    tick();
    idle();

    for (int i = 0; i < 4; i++) begin
      set_req(28'(DMEM + i), 1'b0, 32'h0);
      tick();
    end
    set_req(28'd1028, 1'b0, 32'h0);
    #1 chk("t2_full_yumi", net.yumi_o, 1'b0);
    tick();
    rx_yumi = 1'b1;
    #1 chk("t2_full_pop_yumi", net.yumi_o, 1'b0);
    tick();
    rx_yumi = 1'b0;
    #1 chk("t2_after_pop_yumi", net.yumi_o, 1'b1);
    tick();
    drain();

    set_req(28'd1024, 1'b0, 32'h0);
    tick();
    set_req(28'd1025, 1'b0, 32'h0);
    tick();
    set_req(28'h3FFFFFF, 1'b0, 32'h0);
    tick();
    idle();
    rx_yumi = 1'b1;
    tick();
    tick();
    rx_yumi = 1'b0;
    #1;
    chk("t3_ill_held_v", rx_v, 1'b0);
    chk("t3_ill_held_ret", net.returning_v_o, 1'b0);
    tick();
    ret_v = 1'b1;
    ret_data = 32'h11;
    tick();
    ret_data = 32'h22;
    tick();
    idle();
    #1 chk("t3_err_wait", err, 1'b0);
    tick();
    #1;
    chk("t3_ill_ret_v", net.returning_v_o, 1'b1);
    chk("t3_ill_ret_d", net.returning_data_o, 32'h0);
    chk("t3_err", err, 1'b1);
    chk("t3_err_addr", err_addr, 28'h3FFFFFF);
    tick();
    #1 chk("t3_ret_done", net.returning_v_o, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    chk("t3_clr_err", err, 1'b0);
    chk("t3_clr_addr", err_addr, 28'h0);

    set_req(28'h8004, 1'b1, 32'h1);
    tick();
    idle();
    #1;
    chk("t4_is_csr", rx_is_csr, 1'b1);
    chk("t4_addr", rx_addr, 28'd7);
    drain();

    rx_yumi = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_req(28'(DMEM + 16 + i), 1'b0, 32'h0);
      tick();
    end
    net.v_i = 1'b0;
    tick();
    #1 chk("t5_max_out", rx_v, 1'b0);
    ret_v = 1'b1;
    ret_data = 32'h33;
    tick();
    #1 chk("t5_after_ret", rx_v, 1'b1);
    tick();
    ret_v = 1'b0;
    #1 chk("t5_issue_ret_keep", rx_v, 1'b1);
    tick();
    drain();

    for (int i = 0; i < 600; i++) begin
      if ($urandom % 10 < 6)
        set_req(rand_addr(), 1'($urandom), $urandom);
      else
        net.v_i = 1'b0;
      rx_yumi = 1'($urandom);
      ret_v = (outs > 0) && ($urandom % 10 < 3);
      ret_data = $urandom;
      clr = ($urandom % 20 == 0);
      tick();
    end
    drain();

    set_req(28'h3FFFFFF, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      set_req(28'(DMEM + i), 1'b1, 32'(i + 1));
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_yumi", net.yumi_o, 1'b0);
    chk("t6_rx_v", rx_v, 1'b0);
    chk("t6_ret_v", net.returning_v_o, 1'b0);
    chk("t6_rx_addr", rx_addr, 28'h0);
    chk("t6_rx_we", rx_we, 1'b0);
    chk("t6_is_mem", rx_is_mem, 1'b0);
    chk("t6_err", err, 1'b0);
    chk("t6_err_addr", err_addr, 28'h0);
    model_reset();
    idle();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    set_req(28'd1500, 1'b0, 32'h0);
    tick();
    idle();
    drain();
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
